// File: rtl/shift_command_sequencer_pkg.sv
// Shared types and widths for the shift command sequencer and its FIFO.
// Holds no logic; the command struct is the FIFO entry format.
package shift_seq_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    HOLD
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] inp;
    logic              dir;
    logic [CNT_W-1:0]  cnt;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/shift_command_sequencer_if.sv
// Command, shifter and result signals of the sequencer bundled into one port.
// master is the environment (source, shifter, sink); slave is the sequencer.
interface shift_command_sequencer_if;

  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [shift_seq_pkg::DATA_W-1:0] cmd_inp;
  logic                             cmd_dir;
  logic [shift_seq_pkg::CNT_W-1:0]  cmd_cnt;

  logic                             sh_rst;
  logic [shift_seq_pkg::DATA_W-1:0] sh_inp;
  logic                             sh_dir;
  logic [shift_seq_pkg::CNT_W-1:0]  sh_cnt;
  logic [shift_seq_pkg::DATA_W-1:0] sh_out;

  logic                             res_valid;
  logic                             res_ready;
  logic [shift_seq_pkg::DATA_W-1:0] res_data;

  logic                             busy;

  modport master (
    output cmd_valid, cmd_inp, cmd_dir, cmd_cnt, sh_out, res_ready,
    input  cmd_ready, sh_rst, sh_inp, sh_dir, sh_cnt, res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_inp, cmd_dir, cmd_cnt, sh_out, res_ready,
    output cmd_ready, sh_rst, sh_inp, sh_dir, sh_cnt, res_valid, res_data, busy
  );

endinterface

// File: rtl/shift_command_sequencer_fifo.sv
// Generic DEPTH-entry FIFO; push visible at pop side one cycle later, no bypass.
// Caller gates push with !full and pop with !empty; same-edge push+pop keeps count.
module shift_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/shift_command_sequencer.sv
// Queues shift commands and runs them one at a time through a fixed-latency shifter.
// Result valid N+5+LAT_EXTRA edges after accept; result held until res_ready, no pop meanwhile.
module shift_command_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int LAT_EXTRA = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  shift_command_sequencer_if.slave  bus
);

  localparam int WAIT_W = $clog2((1 << CNT_W) + 2 + LAT_EXTRA);
  localparam int FCW    = $clog2(DEPTH) + 1;

  state_t              state_q, state_d;
  logic                rdy_en_q;
  logic                sh_rst_q, sh_rst_d;
  cmd_t                sh_cmd_q, sh_cmd_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;

  cmd_t                push_cmd;
  cmd_t                head_cmd;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FCW-1:0]      fifo_count;

  assign push_cmd = '{inp: bus.cmd_inp, dir: bus.cmd_dir, cnt: bus.cmd_cnt};
  assign push     = bus.cmd_valid & bus.cmd_ready;

  shift_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_cmd),
    .pop      (pop),
    .pop_dat  (head_cmd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rdy_en_q    <= 1'b0;
      sh_rst_q    <= 1'b1;
      sh_cmd_q    <= '0;
      wait_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      sh_rst_q    <= sh_rst_d;
      sh_cmd_q    <= sh_cmd_d;
      wait_q      <= wait_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_rst_d    = sh_rst_q;
    sh_cmd_d    = sh_cmd_q;
    wait_d      = wait_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        // also drops the post-reset clear on the first edge out of reset
        sh_rst_d = 1'b0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          sh_cmd_d = head_cmd;
          sh_rst_d = 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        sh_rst_d = 1'b0;
        wait_d   = WAIT_W'(sh_cmd_q.cnt) + WAIT_W'(2 + LAT_EXTRA);
        state_d  = RUN;
      end
      RUN: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          res_data_d  = bus.sh_out;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = rdy_en_q & ~fifo_full;
  assign bus.sh_rst    = sh_rst_q;
  assign bus.sh_inp    = sh_cmd_q.inp;
  assign bus.sh_dir    = sh_cmd_q.dir;
  assign bus.sh_cnt    = sh_cmd_q.cnt;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_shift_command_sequencer.sv
// Directed bench: sequencer driving a behavioural 4-bit shifter (dir 0 = left, 1 = arithmetic right).
// Table of single commands with hand-computed results/latencies, plus fill, backpressure and reset sequences.
module tb_shift_command_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  shift_command_sequencer_if bus();

  shift_command_sequencer #(
    .DEPTH     (2),
    .LAT_EXTRA (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shifter: clear while sh_rst, load, shift sh_cnt times, then publish result
  logic [3:0] m_val    = '0;
  logic [3:0] m_out    = '0;
  logic [1:0] m_rem    = '0;
  logic       m_loaded = 1'b0;

  always @(posedge clk) begin
    if (bus.sh_rst) begin
      m_loaded <= 1'b0;
      m_rem    <= '0;
      m_val    <= '0;
      m_out    <= '0;
    end else if (!m_loaded) begin
      m_val    <= bus.sh_inp;
      m_rem    <= bus.sh_cnt;
      m_loaded <= 1'b1;
    end else if (m_rem != 0) begin
      m_val <= bus.sh_dir ? {m_val[3], m_val[3:1]} : {m_val[2:0], 1'b0};
      m_rem <= m_rem - 2'd1;
    end else begin
      m_out <= m_val;
    end
  end
  assign bus.sh_out = m_out;

  // sh_* may only change together with the clear pulse; the pulse is one cycle wide
  int         sh_glitch  = 0;
  int         shrst_long = 0;
  logic       mon_prev_rst   = 1'b0;
  logic       mon_prev_shrst = 1'b0;
  logic [6:0] mon_prev_sh    = '0;

  always @(negedge clk) begin
    if (rst && mon_prev_rst) begin
      if ({bus.sh_inp, bus.sh_dir, bus.sh_cnt} != mon_prev_sh && !bus.sh_rst) sh_glitch++;
      if (bus.sh_rst && mon_prev_shrst) shrst_long++;
    end
    mon_prev_rst   = rst;
    mon_prev_sh    = {bus.sh_inp, bus.sh_dir, bus.sh_cnt};
    mon_prev_shrst = bus.sh_rst;
  end

  typedef struct {
    logic [3:0] inp;
    logic       dir;
    logic [1:0] cnt;
    logic [3:0] res;
    int         lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the sequencer idle and the FIFO empty
  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    bus.cmd_inp   = v.inp;
    bus.cmd_dir   = v.dir;
    bus.cmd_cnt   = v.cnt;
    bus.cmd_valid = 1'b1;
    check({nm, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_lat"}, 32'(lat), 32'(v.lat));
    check({nm, "_data"}, 32'(bus.res_data), 32'(v.res));
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({nm, "_done"}, 32'({bus.res_valid, bus.busy}), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t       vecs[7];
    logic [3:0] got[$];
    logic [3:0] exp_fill[4];
    logic [3:0] d0;
    logic       will_push;
    int         bp_data, bp_pulse, bp_ctl, wcnt, late_valid;

    vecs[0] = '{inp: 4'b0011, dir: 1'b0, cnt: 2'd2, res: 4'b1100, lat: 7};
    vecs[1] = '{inp: 4'b0011, dir: 1'b0, cnt: 2'd0, res: 4'b0011, lat: 5};
    vecs[2] = '{inp: 4'b1000, dir: 1'b1, cnt: 2'd3, res: 4'b1111, lat: 8};
    vecs[3] = '{inp: 4'b0110, dir: 1'b1, cnt: 2'd1, res: 4'b0011, lat: 6};
    vecs[4] = '{inp: 4'b0101, dir: 1'b0, cnt: 2'd1, res: 4'b1010, lat: 6};
    vecs[5] = '{inp: 4'b0111, dir: 1'b0, cnt: 2'd3, res: 4'b1000, lat: 8};
    vecs[6] = '{inp: 4'b0100, dir: 1'b1, cnt: 2'd2, res: 4'b0001, lat: 7};
    exp_fill[0] = 4'b0010;
    exp_fill[1] = 4'b0100;
    exp_fill[2] = 4'b0011;
    exp_fill[3] = 4'b1100;

    bus.cmd_valid = 1'b0;
    bus.cmd_inp   = '0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_cnt   = '0;
    bus.res_ready = 1'b0;

    // Reset
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sh_rst", 32'(bus.sh_rst), 32'd1);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_sh_bus", 32'({bus.sh_inp, bus.sh_dir, bus.sh_cnt}), 32'd0);
    #2 rst = 1'b1;
    #1 check("rel_ready_before_edge", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check("rel_sh_rst", 32'(bus.sh_rst), 32'd0);
    check("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Single commands
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Fill FIFO: A goes in flight, B and C fill the queue, D is held by the source
    bus.cmd_inp = 4'b0001; bus.cmd_dir = 1'b0; bus.cmd_cnt = 2'd1; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_inp = 4'b0010; bus.cmd_dir = 1'b0; bus.cmd_cnt = 2'd1;
    @(negedge clk);
    check("pushpop_ready", 32'(bus.cmd_ready), 32'd1);
    check("pushpop_busy", 32'(bus.busy), 32'd1);
    bus.cmd_inp = 4'b0011; bus.cmd_dir = 1'b1; bus.cmd_cnt = 2'd0;
    @(negedge clk);
    check("full_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_inp = 4'b1001; bus.cmd_dir = 1'b1; bus.cmd_cnt = 2'd1;

    wcnt = 0;
    while (!bus.res_valid && wcnt < 30) begin
      @(negedge clk);
      wcnt++;
    end
    check("bp_first_valid", 32'(bus.res_valid), 32'd1);

    // Backpressure: result frozen, no pop, no clear pulse
    d0 = bus.res_data;
    bp_data = 0; bp_pulse = 0; bp_ctl = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.res_data != d0) bp_data++;
      if (bus.sh_rst) bp_pulse++;
      if (!bus.res_valid || bus.cmd_ready) bp_ctl++;
    end
    check("bp_data_held", 32'(bp_data), 32'd0);
    check("bp_no_sh_rst", 32'(bp_pulse), 32'd0);
    check("bp_valid_full", 32'(bp_ctl), 32'd0);
    check("bp_result_a", 32'(d0), 32'(exp_fill[0]));

    // Drain with res_ready high; D is pushed once a slot frees
    bus.res_ready = 1'b1;
    for (int c = 0; c < 200 && got.size() < 4; c++) begin
      will_push = bus.cmd_valid && bus.cmd_ready;
      if (bus.res_valid) got.push_back(bus.res_data);
      @(negedge clk);
      if (will_push) bus.cmd_valid = 1'b0;
    end
    bus.res_ready = 1'b0;
    check("fill_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++) begin
      check($sformatf("fill_order%0d", i), 32'(got[i]), 32'(exp_fill[i]));
    end
    check("fill_idle", 32'({bus.busy, bus.cmd_valid}), 32'd0);

    // Reset mid-RUN
    bus.cmd_inp = 4'b0001; bus.cmd_dir = 1'b0; bus.cmd_cnt = 2'd3; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_sh_rst", 32'(bus.sh_rst), 32'd1);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", 32'(bus.cmd_ready), 32'd1);
    late_valid = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.res_valid || bus.busy) late_valid++;
      @(negedge clk);
    end
    check("mid_no_result", 32'(late_valid), 32'd0);
    run_vec(vecs[0], "post_rst");

    check("sh_stable", 32'(sh_glitch), 32'd0);
    check("sh_rst_width", 32'(shrst_long), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
